// File: rtl/imem_prog_encoder.sv
// imem_prog_encoder: packs decoded op descriptors into RV32I words and streams them into imem.
// Optional macro IMM_RANGE_CHECK_EN flags immediates that do not fit their field as illegal.
module imem_prog_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_kind,
    input  logic [3:0]        in_aluop,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              overflow,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [31:0]       NOP  = 32'h0000_0013;

    localparam logic [2:0] K_R     = 3'd0;
    localparam logic [2:0] K_I     = 3'd1;
    localparam logic [2:0] K_LW    = 3'd2;
    localparam logic [2:0] K_SW    = 3'd3;
    localparam logic [2:0] K_BEQ   = 3'd4;
    localparam logic [2:0] K_AUIPC = 3'd5;
    localparam logic [2:0] K_LUI   = 3'd6;
    localparam logic [2:0] K_JAL   = 3'd7;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic              full;
    logic              last_seen;
    logic              accept;
    logic              finish;
    logic [31:0]       enc;
    logic              op_bad;
    logic              imm_bad;
    logic              is_shift;
    logic              r_legal;
    logic [2:0]        f3;

    assign accept   = in_valid && in_ready;
    assign finish   = (state == RUN) && (full || last_seen);
    assign f3       = in_aluop[2:0];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // R-type accepts add/sub, the six plain funct3 ops, and srl/sra
    assign r_legal  = !in_aluop[3] || (in_aluop == 4'b1000) ||
                      (in_aluop == 4'b1101);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; start is only looked at in IDLE and DONE
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (finish) state_nx = DONE;
            DONE: if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs decoded from state and the fill/last flags
    always_comb begin
        busy     = (state == RUN);
        done     = (state == DONE);
        in_ready = (state == RUN) && !full && !last_seen;
    end

    // Instruction packing and opcode/aluop legality
    always_comb begin
        enc    = NOP;
        op_bad = 1'b0;
        case (in_kind)
            K_R: begin
                op_bad = !r_legal;
                enc = {in_aluop[3] ? 7'h20 : 7'h00, in_rs2, in_rs1,
                       f3, in_rd, 7'h33};
            end
            K_I: begin
                op_bad = in_aluop[3] && (f3 != 3'b101);
                if (is_shift) begin
                    enc = {1'b0, in_aluop[3], 5'b0, in_imm[4:0],
                           in_rs1, f3, in_rd, 7'h13};
                end else begin
                    enc = {in_imm[11:0], in_rs1, f3, in_rd, 7'h13};
                end
            end
            K_LW: begin
                enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'h03};
            end
            K_SW: begin
                enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                       in_imm[4:0], 7'h23};
            end
            K_BEQ: begin
                enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                       in_imm[4:1], in_imm[11], 7'h63};
            end
            K_AUIPC: begin
                enc = {in_imm[31:12], in_rd, 7'h17};
            end
            K_LUI: begin
                enc = {in_imm[31:12], in_rd, 7'h37};
            end
            K_JAL: begin
                enc = {in_imm[20], in_imm[10:1], in_imm[11],
                       in_imm[19:12], in_rd, 7'h6F};
            end
            default: begin
                enc    = NOP;
                op_bad = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic fit12;
    logic fit13;
    logic fit21;

    // Signed-fit tests: all bits above the field's sign bit match it
    always_comb begin
        fit12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
        fit13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
        fit21 = (&in_imm[31:20]) || !(|in_imm[31:20]);
    end

    // Per-kind immediate range violations
    always_comb begin
        imm_bad = 1'b0;
        case (in_kind)
            K_I:     imm_bad = is_shift ? (|in_imm[31:5]) : !fit12;
            K_LW:    imm_bad = !fit12;
            K_SW:    imm_bad = !fit12;
            K_BEQ:   imm_bad = !fit13 || in_imm[0];
            K_AUIPC: imm_bad = |in_imm[11:0];
            K_LUI:   imm_bad = |in_imm[11:0];
            K_JAL:   imm_bad = !fit21 || in_imm[0];
            default: imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

    // Write pipeline, address pointer and sticky status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= BASE;
            full       <= 1'b0;
            last_seen  <= 1'b0;
            count      <= '0;
            err        <= 1'b0;
            overflow   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
        end else begin
            imem_we <= accept;
            if ((state == IDLE) && start) begin
                ptr       <= BASE;
                full      <= 1'b0;
                last_seen <= 1'b0;
                count     <= '0;
                err       <= 1'b0;
                overflow  <= 1'b0;
            end
            if (accept) begin
                imem_addr  <= ptr;
                imem_wdata <= (op_bad || imm_bad) ? NOP : enc;
                count      <= count + 1'b1;
                if (op_bad || imm_bad) err <= 1'b1;
                if (in_last) last_seen <= 1'b1;
                // Pointer parks on the top word; full blocks further beats
                if (ptr == LAST) begin
                    full <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
            if (finish && full && !last_seen) overflow <= 1'b1;
        end
    end

endmodule

// File: doc/imem_prog_encoder.md
Name: imem_prog_encoder

Overview:
- Encodes a stream of decoded operation descriptors into 32-bit RV32I instruction words and writes them sequentially into instruction memory.
- It is the inverse of the control decoder: the op classes and 4-bit aluop codes it accepts are the ones the decoder emits.
- Sits between the testbench/boot program source and the imem write port, and is used to load programs before the core is released.

Parameters:
- ADDR_W, 8, imem word-address width; capacity is 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begins a program load.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_last  in  1  marks the final descriptor.
- in_kind  in  3  0 R, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5 AUIPC, 6 LUI, 7 JAL.
- in_aluop  in  4  {funct7[5], funct3}, same code as the decoder's aluop.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  byte-offset/immediate, unencoded.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  state==RUN.
- done  out  1  state==DONE.
- err  out  1  sticky; an illegal descriptor was seen.
- overflow  out  1  sticky; imem filled before in_last.
- count  out  ADDR_W+1  words written in the current load.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, err=0, overflow=0, count=0.
- FSM transitions:
  - IDLE->RUN on start=1: address pointer := BASE_ADDR; count, err and overflow cleared.
  - RUN->DONE the cycle after the in_last beat is accepted, or after the last address is written (overflow=1 if in_last has not been seen).
  - DONE->IDLE when start=0.
  - start is ignored while in RUN.
- in_ready = (state==RUN) && !full && !last_seen. Throughput is 1 descriptor/cycle; imem never stalls.
- Latency: a beat accepted at edge N drives imem_we=1 with registered addr/wdata for exactly the cycle after N. Afterwards the pointer increments and count increments.
- full asserts once a write has gone to address 2**ADDR_W-1. The pointer never wraps.
- Encoding (opcode in [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20]):
  - R (0x33): funct7 = aluop[3] ? 0x20 : 0x00; funct3 = aluop[2:0].
  - I-ALU (0x13): imm[11:0] in [31:20].
    - Shifts (funct3 001/101): [31:25] = {1'b0, aluop[3], 5'b0}, [24:20] = imm[4:0].
  - LW (0x03): funct3 = 010, aluop ignored.
  - SW (0x23): funct3 = 010, imm[11:5]->[31:25], imm[4:0]->[11:7].
  - BEQ (0x63): funct3 = 000, {imm[12], imm[10:5]}->[31:25], {imm[4:1], imm[11]}->[11:7].
  - AUIPC (0x17) / LUI (0x37): imm[31:12]->[31:12].
  - JAL (0x6F): {imm[20], imm[10:1], imm[11], imm[19:12]}->[31:12].
- Illegal descriptors: R aluop outside {0000,1000,0001,0010,0011,0100,0101,1101,0110,0111}, or I-ALU with aluop[3]=1 and funct3 != 101.
  - Write the NOP 0x00000013 in place of the instruction.
  - Set err; the write still consumes an address.
- Reset asserted mid-load aborts immediately. Partially written imem contents are left as-is.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: an immediate that does not fit its field is treated as illegal (NOP written, err set). Fit conditions:
  - I/LW/SW: sign-extension of 12 bits.
  - BEQ: 13-bit signed, bit0=0.
  - JAL: 21-bit signed, bit0=0.
  - Shifts: imm[31:5]==0.
  - LUI/AUIPC: imm[11:0]==0.
- Undefined: upper immediate bits are silently truncated; no error is raised for immediates.

Test Plan:
- Single-beat encodes, each with in_last=1:
  - R, aluop 0000, rd3 rs1=1 rs2=2 -> 0x002081B3 at addr 0.
  - R, aluop 1000, rd5 rs1=6 rs2=7 -> 0x407302B3.
- Back-to-back burst, in_valid held 4 cycles:
  - addi x1,x0,-1 -> 0xFFF00093; lw x4,4(x1) -> 0x0040A203; sw x2,8(x1) -> 0x0020A423; beq x1,x2,8 (in_last) -> 0x00208463.
  - Required: addrs 0..3 on consecutive cycles, count=4, done=1.
- jal x1,8 -> 0x008000EF. R with aluop 1001 -> 0x00000013 written and err=1.
- ADDR_W=2, 5 beats with no in_last: 4 writes, in_ready drops after the 4th accept, overflow=1, done=1. Then start=0 -> IDLE.
- rst_n pulsed low mid-burst: all outputs return to reset values asynchronously. A new start reloads from BASE_ADDR.
- IMM_RANGE_CHECK_EN defined, addi with imm=0x800: err=1 and NOP written. Undefined: 0x80000013 written, err=0.
